des_output_serializer: RTL and testbench

//  Downstream stage of the DES control unit. Captures the 64-bit DES result when the controller

---
 rtl/des_output_serializer_if.sv | 24 ++
 rtl/des_output_serializer.sv | 99 +++++++++
 tb/tb_des_output_serializer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/des_output_serializer_if.sv
// Handshake bundle between the DES result serializer and its controller / USB TX neighbours.
interface des_output_serializer_if #(
    parameter int unsigned BLOCK_BITS = 64,
    parameter int unsigned CNT_W      = 16
);
    logic                  data_out;
    logic [BLOCK_BITS-1:0] des_result;
    logic                  tx_ready;
    logic [7:0]            tx_byte;
    logic                  tx_valid;
    logic                  tx_last;
    logic                  empty;
    logic [CNT_W-1:0]      block_count;

    modport master (
        input  data_out, des_result, tx_ready,
        output tx_byte, tx_valid, tx_last, empty, block_count
    );

    modport slave (
        output data_out, des_result, tx_ready,
        input  tx_byte, tx_valid, tx_last, empty, block_count
    );
endinterface

// File: rtl/des_output_serializer.sv
// Captures a DES result block and streams it out one byte per valid/ready handshake,
// pulsing empty for one cycle after the final byte and counting completed blocks.
module des_output_serializer #(
    parameter int unsigned BLOCK_BITS = 64,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter int unsigned CNT_W      = 16
) (
    input logic                    clk,
    input logic                    n_rst,
    des_output_serializer_if.master bus
);
    localparam int unsigned NumBytes = BLOCK_BITS / 8;
    localparam int unsigned IdxW     = (NumBytes > 1) ? $clog2(NumBytes) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumBytes - 1);

    typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

    state_e                state_q;
    logic [BLOCK_BITS-1:0] shreg_q;
    logic [IdxW-1:0]       byte_idx_q;
    logic                  armed_q;
    logic [7:0]            tx_byte_q;
    logic                  tx_valid_q;
    logic                  tx_last_q;
    logic                  empty_q;
    logic [CNT_W-1:0]      block_count_q;
    logic [IdxW-1:0]       next_idx;

    assign next_idx = byte_idx_q + 1'b1;

    function automatic logic [7:0] pick_byte(input logic [BLOCK_BITS-1:0] blk,
                                             input logic [IdxW-1:0] idx);
        int unsigned pos;
        int unsigned lsb;
        pos = 32'(idx) * 8;
        lsb = MSB_FIRST ? (BLOCK_BITS - 8 - pos) : pos;
        return blk[lsb +: 8];
    endfunction

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= StIdle;
            shreg_q       <= '0;
            byte_idx_q    <= '0;
            armed_q       <= 1'b1;
            tx_byte_q     <= '0;
            tx_valid_q    <= 1'b0;
            tx_last_q     <= 1'b0;
            empty_q       <= 1'b0;
            block_count_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.data_out && armed_q) begin
                        shreg_q    <= bus.des_result;
                        byte_idx_q <= '0;
                        armed_q    <= 1'b0;
                        tx_byte_q  <= pick_byte(bus.des_result, '0);
                        tx_valid_q <= 1'b1;
                        tx_last_q  <= (LastIdx == '0);
                        state_q    <= StSend;
                    end else if (!bus.data_out) begin
                        armed_q <= 1'b1;
                    end
                end
                StSend: begin
                    // data_out is deliberately ignored here; re-arming only happens in IDLE/DONE.
                    if (bus.tx_ready) begin
                        if (byte_idx_q == LastIdx) begin
                            tx_valid_q <= 1'b0;
                            tx_last_q  <= 1'b0;
                            empty_q    <= 1'b1;
                            state_q    <= StDone;
                        end else begin
                            byte_idx_q <= next_idx;
                            tx_byte_q  <= pick_byte(shreg_q, next_idx);
                            tx_last_q  <= (next_idx == LastIdx);
                        end
                    end
                end
                StDone: begin
                    empty_q       <= 1'b0;
                    block_count_q <= block_count_q + 1'b1;
                    if (!bus.data_out) begin
                        armed_q <= 1'b1;
                    end
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.tx_byte     = tx_byte_q;
    assign bus.tx_valid    = tx_valid_q;
    assign bus.tx_last     = tx_last_q;
    assign bus.empty       = empty_q;
    assign bus.block_count = block_count_q;
endmodule

// File: tb/tb_des_output_serializer.sv
// Scoreboard bench: three serializer variants (MSB-first, LSB-first, 2-bit counter) share stimulus.
module tb_des_output_serializer;
    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        data_out = 1'b0;
    logic [63:0] des_result = '0;
    logic        tx_ready = 1'b0;

    always #5 clk = ~clk;

    des_output_serializer_if #(.BLOCK_BITS(64), .CNT_W(16)) bus0 ();
    des_output_serializer_if #(.BLOCK_BITS(64), .CNT_W(16)) bus1 ();
    des_output_serializer_if #(.BLOCK_BITS(64), .CNT_W(2))  bus2 ();

    assign bus0.data_out = data_out;
    assign bus0.des_result = des_result;
    assign bus0.tx_ready = tx_ready;
    assign bus1.data_out = data_out;
    assign bus1.des_result = des_result;
    assign bus1.tx_ready = tx_ready;
    assign bus2.data_out = data_out;
    assign bus2.des_result = des_result;
    assign bus2.tx_ready = tx_ready;

    des_output_serializer #(.BLOCK_BITS(64), .MSB_FIRST(1'b1), .CNT_W(16)) u_dut_msb (
        .clk(clk), .n_rst(n_rst), .bus(bus0)
    );
    des_output_serializer #(.BLOCK_BITS(64), .MSB_FIRST(1'b0), .CNT_W(16)) u_dut_lsb (
        .clk(clk), .n_rst(n_rst), .bus(bus1)
    );
    des_output_serializer #(.BLOCK_BITS(64), .MSB_FIRST(1'b1), .CNT_W(2)) u_dut_cnt2 (
        .clk(clk), .n_rst(n_rst), .bus(bus2)
    );

    logic [7:0]  byte_a[3];
    logic        val_a[3];
    logic        last_a[3];
    logic        empty_a[3];
    logic [15:0] cnt_a[3];

    assign byte_a[0] = bus0.tx_byte;
    assign byte_a[1] = bus1.tx_byte;
    assign byte_a[2] = bus2.tx_byte;
    assign val_a[0] = bus0.tx_valid;
    assign val_a[1] = bus1.tx_valid;
    assign val_a[2] = bus2.tx_valid;
    assign last_a[0] = bus0.tx_last;
    assign last_a[1] = bus1.tx_last;
    assign last_a[2] = bus2.tx_last;
    assign empty_a[0] = bus0.empty;
    assign empty_a[1] = bus1.empty;
    assign empty_a[2] = bus2.empty;
    assign cnt_a[0] = bus0.block_count;
    assign cnt_a[1] = bus1.block_count;
    assign cnt_a[2] = {14'b0, bus2.block_count};

    int n_checks = 0;
    int n_fail = 0;

    // Expected {byte, last} per DUT, in send order.
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] q2[$];

    bit          pend_done[3];
    bit          pend_cnt[3];
    bit          held[3];
    logic [7:0]  held_byte[3];
    logic [15:0] exp_cnt[3];
    logic [8:0]  mon_e;
    bit          mon_ok;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] cnt_mask(input int i);
        return (i == 2) ? 16'h0003 : 16'hFFFF;
    endfunction

    task automatic pop_exp(input int i, output logic [8:0] e, output bit ok);
        ok = 1'b0;
        e  = '0;
        case (i)
            0: if (q0.size() != 0) begin e = q0.pop_front(); ok = 1'b1; end
            1: if (q1.size() != 0) begin e = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() != 0) begin e = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    task automatic flush_queues();
        q0.delete();
        q1.delete();
        q2.delete();
    endtask

    always @(negedge clk) begin
        if (!n_rst) begin
            for (int i = 0; i < 3; i++) begin
                pend_done[i] = 1'b0;
                pend_cnt[i]  = 1'b0;
                held[i]      = 1'b0;
                exp_cnt[i]   = '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                check_eq($sformatf("empty[%0d]", i), empty_a[i], pend_done[i]);
                if (pend_cnt[i]) exp_cnt[i] = (exp_cnt[i] + 16'd1) & cnt_mask(i);
                check_eq($sformatf("block_count[%0d]", i), cnt_a[i], exp_cnt[i]);
                pend_cnt[i]  = pend_done[i];
                pend_done[i] = 1'b0;
                if (held[i]) begin
                    check_eq($sformatf("hold[%0d]", i), {val_a[i], byte_a[i]},
                             {1'b1, held_byte[i]});
                end
                if (val_a[i] && tx_ready) begin
                    held[i] = 1'b0;
                    pop_exp(i, mon_e, mon_ok);
                    if (!mon_ok) begin
                        check_eq($sformatf("spurious_valid[%0d]", i), val_a[i], 1'b0);
                    end else begin
                        check_eq($sformatf("byte[%0d]", i), byte_a[i], mon_e[8:1]);
                        check_eq($sformatf("last[%0d]", i), last_a[i], mon_e[0]);
                        pend_done[i] = mon_e[0];
                    end
                end else if (val_a[i]) begin
                    held[i]      = 1'b1;
                    held_byte[i] = byte_a[i];
                end else begin
                    held[i] = 1'b0;
                end
            end
        end
    end

    task automatic push_block(input logic [63:0] blk);
        for (int i = 0; i < 8; i++) begin
            q0.push_back({blk[63 - 8 * i -: 8], i == 7});
            q1.push_back({blk[8 * i +: 8], i == 7});
            q2.push_back({blk[63 - 8 * i -: 8], i == 7});
        end
    endtask

    function automatic logic ready_for(input int mode, input int n);
        case (mode)
            0: return 1'b1;
            1: return (n % 3) == 0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Starts from the cycle after a block's DONE state (or idle), so the DUT is in IDLE when sampled.
    task automatic send_block(input logic [63:0] blk, input int mode, input bit hold);
        int n;
        n = 0;
        @(posedge clk); #1;
        push_block(blk);
        des_result = blk;
        data_out   = 1'b1;
        tx_ready   = ready_for(mode, 0);
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) check_eq("latency", val_a[0], 1'b1);
            if (!hold) data_out = 1'b0;
            des_result = {$urandom, $urandom};
            tx_ready   = ready_for(mode, n);
        end while ((q0.size() + q1.size() + q2.size()) != 0 && n < 200);
        if (n >= 200) begin
            check_eq("drain_timeout", q0.size() + q1.size() + q2.size(), 0);
            flush_queues();
        end
        if (mode == 0) check_eq("drain_cycles", n, 9);
    endtask

    task automatic reset_mid(input logic [63:0] blk);
        @(posedge clk); #1;
        push_block(blk);
        des_result = blk;
        data_out   = 1'b1;
        tx_ready   = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            data_out = 1'b0;
        end
        check_eq("pre_reset_valid", val_a[0], 1'b1);
        #2 n_rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("async_reset_out[%0d]", i),
                     {byte_a[i], val_a[i], last_a[i], empty_a[i]}, '0);
            check_eq($sformatf("async_reset_cnt[%0d]", i), cnt_a[i], '0);
        end
        flush_queues();
        @(posedge clk); #3;
        n_rst = 1'b1;
    endtask

    logic [15:0] exp_c2[5];

    initial begin
        exp_c2[0] = 16'd1;
        exp_c2[1] = 16'd2;
        exp_c2[2] = 16'd3;
        exp_c2[3] = 16'd0;
        exp_c2[4] = 16'd1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("reset_out[%0d]", i),
                     {byte_a[i], val_a[i], last_a[i], empty_a[i]}, '0);
            check_eq($sformatf("reset_cnt[%0d]", i), cnt_a[i], '0);
        end
        repeat (2) @(posedge clk);
        #3 n_rst = 1'b1;

        send_block(64'h0123456789ABCDEF, 0, 1'b0);
        @(posedge clk); #1;
        check_eq("count_after_1", cnt_a[0], 16'd1);

        send_block(64'h0123456789ABCDEF, 1, 1'b0);
        send_block(64'hDEADBEEFCAFEF00D, 2, 1'b0);
        send_block(64'h8000000000000001, 2, 1'b0);

        // data_out held high through DONE must not start a second block.
        send_block(64'hA5A55A5A0F0FF0F0, 0, 1'b1);
        repeat (5) begin
            @(negedge clk);
            check_eq("no_recapture", val_a[0], 1'b0);
        end
        @(posedge clk); #1;
        data_out = 1'b0;
        send_block(64'h1122334455667788, 1, 1'b0);

        reset_mid(64'hFFEEDDCCBBAA9988);
        send_block(64'h0123456789ABCDEF, 0, 1'b0);

        reset_mid(64'h0000000000000000);
        for (int k = 0; k < 5; k++) begin
            send_block({$urandom, $urandom}, 0, 1'b0);
            @(posedge clk); #1;
            check_eq($sformatf("cnt2_block%0d", k), cnt_a[2], exp_c2[k]);
        end
        reset_mid(64'h13579BDF2468ACE0);
        repeat (4) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end
endmodule
